// File: rtl/weight_mem_ctrl.sv
// -----------------------------------------------------------------------------
// weight_mem_ctrl
//
// Parametrised weight memory sitting between the weight loader and the MAC
// array's weight fetch stage. Holds DATA_DEPTH weights of DATA_WIDTH bits,
// written through a simple strobe port and read through a valid/ready request
// and response pipeline of READ_LATENCY stages with backpressure. The memory
// zeroes itself after reset and on a clr_start pulse (in-flight reads are
// drained first).
//
// Optional feature: define WEIGHT_MEM_PARITY_EN to store one even-parity bit
// per entry and flag mismatches on rd_parity_err. Without it, rd_parity_err
// is tied low.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clr_start             pulse: zero the whole memory (honoured in RUN only)
//   busy                  high while draining or clearing
//   wr_en/wr_addr/wr_data write port, no handshake, RUN only
//   rd_addr/_valid/_ready read request channel
//   rd_data/_valid/_ready read response channel
//   rd_parity_err         parity mismatch, qualified by rd_data_valid
// -----------------------------------------------------------------------------
module weight_mem_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int DATA_DEPTH   = 256,
  parameter int ADDR_WIDTH   = $clog2(DATA_DEPTH),
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_start,
  output logic                  busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_addr_valid,
  output logic                  rd_addr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  input  logic                  rd_data_ready,
  output logic                  rd_parity_err
);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Depth widened by one bit so a depth that is not a power of two still
  // compares correctly against a full-range address.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   sweep_q, sweep_d;

  logic                    advance;
  logic                    accept;
  logic                    any_valid;
  logic                    clr_we;

  logic                    wr_in_range;
  logic                    rd_in_range;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    rd_err;

  logic [DATA_WIDTH-1:0]   mem_q [DATA_DEPTH];

  logic [READ_LATENCY-1:0] vld_q;
  logic [READ_LATENCY-1:0] err_q;
  logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    sweep_d       = '0;
    busy          = 1'b1;
    rd_addr_ready = 1'b0;
    clr_we        = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we  = 1'b1;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == LAST_ADDR) begin
          state_d = RUN;
          sweep_d = '0;
        end
      end
      RUN: begin
        busy          = 1'b0;
        rd_addr_ready = advance;
        if (clr_start) state_d = DRAIN;
      end
      DRAIN: begin
        // No new requests enter, so once every stage is empty it stays empty.
        if (!any_valid) state_d = CLEAR;
      end
      default: state_d = CLEAR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);

  // The clear sweep owns the write port while in CLEAR; user writes only land
  // in RUN and only for addresses that exist.
  assign mem_we    = clr_we || ((state_q == RUN) && wr_en && wr_in_range);
  assign mem_waddr = clr_we ? sweep_q : wr_addr;
  assign mem_wdata = clr_we ? '0 : wr_data;

  // NOTE: the array has no reset; the CLEAR sweep after every reset zeroes it,
  // which keeps it mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Combinational read at the accept edge sees the pre-write contents, so a
  // same-cycle write to the same address returns the old word.
  assign rd_word = rd_in_range ? mem_q[rd_addr] : '0;

`ifdef WEIGHT_MEM_PARITY_EN
  // Even parity: stored bit equals XOR of the data, so a cleared entry is 0.
  logic par_q [DATA_DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) par_q[mem_waddr] <= ^mem_wdata;
  end

  assign rd_err = rd_in_range && (par_q[rd_addr] != (^mem_q[rd_addr]));
`else
  assign rd_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read pipeline: one global advance, every stage holds while the output
  // stage is valid and not consumed.
  // ---------------------------------------------------------------------------
  assign advance   = !(vld_q[READ_LATENCY-1] && !rd_data_ready);
  assign accept    = rd_addr_valid && rd_addr_ready;
  assign any_valid = |vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else if (advance) begin
      vld_q[0] <= accept;
      dat_q[0] <= rd_word;
      err_q[0] <= rd_err;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
        err_q[i] <= err_q[i-1];
      end
    end
  end

  assign rd_data_valid = vld_q[READ_LATENCY-1];
  assign rd_data       = dat_q[READ_LATENCY-1];
  assign rd_parity_err = err_q[READ_LATENCY-1];

endmodule

// File: tb/tb_weight_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_weight_mem_ctrl
//
// Directed self-checking bench for weight_mem_ctrl at default parameters
// (8-bit data, 256 entries, read latency 2). Inputs change on the falling
// edge; outputs are sampled on the falling edge (or 1 time unit after it).
// Build with WEIGHT_MEM_PARITY_EN defined to include the parity scenario.
// -----------------------------------------------------------------------------
module tb_weight_mem_ctrl;

  logic       clk;
  logic       rst_n;
  logic       clr_start;
  logic       busy;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic       rd_addr_valid;
  logic       rd_addr_ready;
  logic [7:0] rd_data;
  logic       rd_data_valid;
  logic       rd_data_ready;
  logic       rd_parity_err;

  int n_checks = 0;
  int n_errors = 0;

  weight_mem_ctrl #(
    .DATA_WIDTH  (8),
    .DATA_DEPTH  (256),
    .READ_LATENCY(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_start    (clr_start),
    .busy         (busy),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_addr      (rd_addr),
    .rd_addr_valid(rd_addr_valid),
    .rd_addr_ready(rd_addr_ready),
    .rd_data      (rd_data),
    .rd_data_valid(rd_data_valid),
    .rd_data_ready(rd_data_ready),
    .rd_parity_err(rd_parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_word(input logic [7:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Single read from an empty pipeline, optionally with a same-cycle write to
  // the same address. Called and returns on a falling edge.
  task automatic read_one(input logic [7:0] addr, input logic do_wr, input logic [7:0] wdata,
                          output logic [7:0] data, output logic err, output int lat);
    int guard;
    guard         = 0;
    rd_addr       = addr;
    rd_addr_valid = 1'b1;
    rd_data_ready = 1'b1;
    wr_en         = do_wr;
    wr_addr       = addr;
    wr_data       = wdata;
    #1;
    while (!rd_addr_ready && guard < 50) begin
      @(negedge clk);
      guard++;
      #1;
    end
    if (!rd_addr_ready) check("rd_accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    rd_addr_valid = 1'b0;
    wr_en         = 1'b0;
    lat           = 1;
    #1;
    while (!rd_data_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      #1;
    end
    data = rd_data;
    err  = rd_parity_err;
    @(negedge clk);
  endtask

  // Counts falling-edge samples while busy. Optionally drives a write on a
  // chosen busy cycle (it must be ignored). Called on a falling edge.
  task automatic wait_clear(input int wr_at, output int cycles, output int bad_ready,
                            output int bad_valid);
    cycles    = 0;
    bad_ready = 0;
    bad_valid = 0;
    while (busy && cycles < 2000) begin
      if (rd_addr_ready) bad_ready++;
      if (rd_data_valid) bad_valid++;
      if (cycles == wr_at) begin
        wr_en   = 1'b1;
        wr_addr = 8'h22;
        wr_data = 8'h66;
      end else begin
        wr_en = 1'b0;
      end
      cycles++;
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  // Eight back-to-back reads of entries 0..7 (preloaded with 0x30+i) while
  // rd_data_ready follows a 4-cycle pattern.
  task automatic burst(input logic [3:0] pat, output int n_resp, output int n_cyc,
                       output int bad_order, output int bad_ready, output int bad_hold);
    int         req;
    int         k;
    logic       hold_pend;
    logic [7:0] held;
    logic [7:0] exp;
    req       = 0;
    k         = 0;
    n_resp    = 0;
    bad_order = 0;
    bad_ready = 0;
    bad_hold  = 0;
    hold_pend = 1'b0;
    held      = '0;
    while (n_resp < 8 && k < 100) begin
      rd_data_ready = pat[k % 4];
      rd_addr_valid = (req < 8);
      rd_addr       = req[7:0];
      #1;
      if (hold_pend && (!rd_data_valid || rd_data !== held)) bad_hold++;
      if (rd_addr_ready !== !(rd_data_valid && !rd_data_ready)) bad_ready++;
      if (rd_addr_valid && rd_addr_ready) req++;
      if (rd_data_valid && rd_data_ready) begin
        exp = 8'(8'h30 + n_resp);
        if (rd_data !== exp) bad_order++;
        n_resp++;
      end
      hold_pend = rd_data_valid && !rd_data_ready;
      held      = rd_data;
      k++;
      @(negedge clk);
    end
    rd_addr_valid = 1'b0;
    rd_data_ready = 1'b1;
    n_cyc         = k;
  endtask

  initial begin
    logic [7:0] d;
    logic       e;
    int         lat;
    int         cyc;
    int         br;
    int         bv;
    int         nr;
    int         bo;
    int         bh;
    int         tot;
    logic [7:0] tab_addr [3];
    logic [7:0] tab_exp  [3];
    logic [7:0] got_q [$];

    rst_n         = 1'b0;
    clr_start     = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    rd_addr       = 8'h10;
    rd_addr_valid = 1'b1;
    rd_data_ready = 1'b1;

    // Reset values
    #1;
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_rd_data_valid", 32'(rd_data_valid), 32'h0);
    check("rst_parity_err", 32'(rd_parity_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_rd_addr_ready", 32'(rd_addr_ready), 32'h0);

    // Clear after reset with a request held pending
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear(-1, cyc, br, bv);
    check("clear_len_after_reset", 32'(cyc), 32'd256);
    check("ready_while_clearing", 32'(br), 32'd0);
    check("valid_while_clearing", 32'(bv), 32'd0);
    read_one(8'h10, 1'b0, 8'h00, d, e, lat);
    check("first_read_data", 32'(d), 32'h00);
    check("first_read_latency", 32'(lat), 32'd2);

    // Write then read, and same-cycle read/write
    write_word(8'h03, 8'hA5);
    read_one(8'h03, 1'b0, 8'h00, d, e, lat);
    check("wr_then_rd_data", 32'(d), 32'hA5);
    check("wr_then_rd_latency", 32'(lat), 32'd2);
    check("wr_then_rd_parity", 32'(e), 32'h0);
    read_one(8'h03, 1'b1, 8'h5A, d, e, lat);
    check("same_cycle_rd_old", 32'(d), 32'hA5);
    read_one(8'h03, 1'b0, 8'h00, d, e, lat);
    check("same_cycle_wr_landed", 32'(d), 32'h5A);

    // Preload for bursts and the clear scenario; 0xFF is the last entry
    for (int i = 0; i < 8; i++) write_word(8'(i), 8'(8'h30 + i));
    write_word(8'h20, 8'h7F);
    write_word(8'hFF, 8'hEE);
    read_one(8'hFF, 1'b0, 8'h00, d, e, lat);
    check("last_entry_data", 32'(d), 32'hEE);

    // Full-throughput burst
    burst(4'b1111, nr, cyc, bo, br, bh);
    check("burst_full_resp", 32'(nr), 32'd8);
    check("burst_full_cycles", 32'(cyc), 32'd10);
    check("burst_full_order", 32'(bo), 32'd0);
    check("burst_full_ready", 32'(br), 32'd0);

    // Backpressured burst, ready pattern 1,0,0,1
    burst(4'b1001, nr, cyc, bo, br, bh);
    check("burst_stall_resp", 32'(nr), 32'd8);
    check("burst_stall_order", 32'(bo), 32'd0);
    check("burst_stall_ready", 32'(br), 32'd0);
    check("burst_stall_hold", 32'(bh), 32'd0);

    // clr_start with three reads in flight
    tab_addr[0] = 8'h20; tab_exp[0] = 8'h7F;
    tab_addr[1] = 8'h03; tab_exp[1] = 8'h33;
    tab_addr[2] = 8'hFF; tab_exp[2] = 8'hEE;
    tot = 0;
    bv  = 0;
    br  = 0;
    for (int c = 0; c < 6; c++) begin
      rd_data_ready = 1'b1;
      rd_addr_valid = (c < 3);
      rd_addr       = (c < 3) ? tab_addr[c] : 8'h00;
      clr_start     = (c == 3);
      #1;
      if (rd_data_valid) got_q.push_back(rd_data);
      if (c < 3 && !rd_addr_ready) br++;
      if (c >= 4) begin
        tot++;
        if (!busy) bv++;
        if (rd_addr_ready) br++;
      end
      @(negedge clk);
    end
    clr_start = 1'b0;
    check("drain_resp_count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) check("drain_resp_data", 32'(got_q[i]), 32'(tab_exp[i]));
    end
    check("drain_busy", 32'(bv), 32'd0);
    wait_clear(200, cyc, nr, bo);
    check("drain_clear_busy_len", 32'(tot + cyc), 32'd258);
    check("drain_clear_ready", 32'(br + nr), 32'd0);
    check("drain_clear_valid", 32'(bo), 32'd0);
    read_one(8'h20, 1'b0, 8'h00, d, e, lat);
    check("cleared_0x20", 32'(d), 32'h00);
    read_one(8'h22, 1'b0, 8'h00, d, e, lat);
    check("write_during_clear_dropped", 32'(d), 32'h00);

    // Reset in the middle of a burst with a response on the output
    begin
      int c;
      c = 0;
      rd_data_ready = 1'b1;
      rd_addr_valid = 1'b1;
      rd_addr       = 8'h00;
      #1;
      while (!rd_data_valid && c < 20) begin
        @(negedge clk);
        c++;
        rd_addr = 8'(c);
        #1;
      end
      check("midburst_valid_seen", 32'(rd_data_valid), 32'h1);
      rst_n = 1'b0;
      #1;
      check("midrst_rd_data", 32'(rd_data), 32'h0);
      check("midrst_rd_data_valid", 32'(rd_data_valid), 32'h0);
      check("midrst_busy", 32'(busy), 32'h1);
      check("midrst_rd_addr_ready", 32'(rd_addr_ready), 32'h0);
      rd_addr_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
    wait_clear(-1, cyc, br, bv);
    check("midrst_clear_len", 32'(cyc), 32'd256);
    check("midrst_no_stale_resp", 32'(bv), 32'd0);
    read_one(8'h03, 1'b0, 8'h00, d, e, lat);
    check("midrst_cleared_0x03", 32'(d), 32'h00);
    check("midrst_parity", 32'(e), 32'h0);

`ifdef WEIGHT_MEM_PARITY_EN
    write_word(8'h05, 8'h01);
    write_word(8'h06, 8'h01);
    dut.mem_q[5] = dut.mem_q[5] ^ 8'h02;
    read_one(8'h05, 1'b0, 8'h00, d, e, lat);
    check("parity_flip_data", 32'(d), 32'h03);
    check("parity_flip_err", 32'(e), 32'h1);
    read_one(8'h06, 1'b0, 8'h00, d, e, lat);
    check("parity_clean_data", 32'(d), 32'h01);
    check("parity_clean_err", 32'(e), 32'h0);
`else
    write_word(8'h05, 8'h01);
    read_one(8'h05, 1'b0, 8'h00, d, e, lat);
    check("noparity_data", 32'(d), 32'h01);
    check("noparity_err", 32'(e), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
